// File: rtl/risc16_pkg.sv
// Shared address map and status-word layout for the risc16 memory responder.
package risc16_pkg;

    localparam logic [15:0] IO_BASE    = 16'hFF00;
    localparam logic [7:0]  TXDATA_OFS = 8'h00;
    localparam logic [7:0]  STATUS_OFS = 8'h02;
    localparam logic [7:0]  CYCLES_OFS = 8'h04;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    function automatic logic [15:0] make_status(input logic ovf, input logic full, input logic empty);
        logic [15:0] s;
        s           = '0;
        s[ST_OVF]   = ovf;
        s[ST_FULL]  = full;
        s[ST_EMPTY] = empty;
        return s;
    endfunction

endpackage

// File: rtl/risc16_io_fifo.sv
// Small synchronous FIFO feeding the TX byte port; reports pushes dropped while full.
module risc16_io_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty,
    output logic         o_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_pop;
    logic          w_push;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
    assign w_pop   = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_head  = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/risc16_mem_responder.sv
// Memory-side responder for the risc16 core: word RAM plus an I/O page with TX FIFO, status and cycle counter.
module risc16_mem_responder
    import risc16_pkg::*;
#(
    parameter int RAM_AW     = 11,
    parameter int FIFO_DEPTH = 4,
    parameter     INIT_FILE  = ""
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_dout,
    input  logic        i_cpu_oe,
    input  logic        i_cpu_we,
    output logic [15:0] o_cpu_din,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready
);
    logic [15:0]       r_ram [2**RAM_AW];
    logic [15:0]       r_cycles;
    logic              r_ovf;

    logic              w_is_io;
    logic [7:0]        w_io_ofs;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_tx;
    logic              w_wr_status;
    logic              w_wr_cycles;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [15:0]       w_status;
    logic [15:0]       w_rd_data;
    logic              w_unused_addr0;

    assign w_unused_addr0 = i_cpu_addr[0];
    assign w_is_io        = (i_cpu_addr[15:8] == IO_BASE[15:8]);
    assign w_io_ofs       = {i_cpu_addr[7:1], 1'b0};
    assign w_ram_idx      = i_cpu_addr[RAM_AW:1];
    assign w_wr_tx        = i_cpu_we & w_is_io & (w_io_ofs == TXDATA_OFS);
    assign w_wr_status    = i_cpu_we & w_is_io & (w_io_ofs == STATUS_OFS);
    assign w_wr_cycles    = i_cpu_we & w_is_io & (w_io_ofs == CYCLES_OFS);
    assign w_status       = make_status(r_ovf, w_full, w_empty);
    assign o_tx_valid     = ~w_empty;

    risc16_io_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_wr_tx),
        .i_data  (i_cpu_dout[7:0]),
        .i_pop   (o_tx_valid & i_tx_ready),
        .o_head  (o_tx_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // Read path stays combinational: the core latches din on the same edge it drives oe.
    always_comb begin
        w_rd_data = '0;
        if (i_cpu_oe) begin
            if (w_is_io) begin
                case (w_io_ofs)
                    STATUS_OFS: w_rd_data = w_status;
                    CYCLES_OFS: w_rd_data = r_cycles;
                    default:    w_rd_data = '0;
                endcase
            end else begin
                w_rd_data = r_ram[w_ram_idx];
            end
        end
    end
    assign o_cpu_din = w_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_cpu_we && !w_is_io) r_ram[w_ram_idx] <= i_cpu_dout;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycles <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_cycles <= w_wr_cycles ? 16'h0000 : r_cycles + 16'h0001;
            if (w_wr_status)  r_ovf <= 1'b0;
            else if (w_drop)  r_ovf <= 1'b1;
        end
    end

endmodule
